// File: rtl/seq_dec_pkg.sv
// Shared opcodes, control-word layout, canned words and FSM states for the decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_dec_pkg;

    localparam logic [4:0] OP_RESET     = 5'b00000;
    localparam logic [4:0] OP_FETCH_PC  = 5'b01000;
    localparam logic [4:0] OP_FETCH_RD  = 5'b01001;
    localparam logic [4:0] OP_LOAD_R    = 5'b01010;
    localparam logic [4:0] OP_PUSH_PC   = 5'b01011;
    localparam logic [4:0] OP_POP       = 5'b01100;
    localparam logic [4:0] OP_LOAD_CNT  = 5'b01101;
    localparam logic [4:0] OP_REPEAT    = 5'b01110;
    localparam logic [4:0] OP_COND_JUMP = 5'b01111;

    typedef struct packed {
        logic       cen;
        logic       rst;
        logic       oen;
        logic       inc;
        logic       rsel;
        logic       rce;
        logic       pc_mux_sel;
        logic       push;
        logic       pop;
        logic       src_sel;
        logic       stack_we;
        logic       stack_re;
        logic       out_ce;
        logic [1:0] a_mux_sel;
        logic [1:0] b_mux_sel;
    } ctrl_word_t;

    // Quiescent word: PC takes its incrementer path, both ALU muxes park on input 2.
    localparam ctrl_word_t IDLE_WORD = '{
        cen: 1'b0, rst: 1'b0, oen: 1'b0, inc: 1'b0, rsel: 1'b0, rce: 1'b0,
        pc_mux_sel: 1'b1, push: 1'b0, pop: 1'b0, src_sel: 1'b0,
        stack_we: 1'b0, stack_re: 1'b0, out_ce: 1'b0,
        a_mux_sel: 2'b10, b_mux_sel: 2'b10};

    // Instruction disable: output enable only, nothing advances.
    localparam ctrl_word_t DISABLE_WORD = '{
        cen: 1'b0, rst: 1'b0, oen: 1'b1, inc: 1'b0, rsel: 1'b0, rce: 1'b0,
        pc_mux_sel: 1'b1, push: 1'b0, pop: 1'b0, src_sel: 1'b0,
        stack_we: 1'b0, stack_re: 1'b0, out_ce: 1'b0,
        a_mux_sel: 2'b10, b_mux_sel: 2'b10};

    // Also the word repeated on every LOOP cycle.
    localparam ctrl_word_t FETCH_PC_WORD = '{
        cen: 1'b0, rst: 1'b0, oen: 1'b1, inc: 1'b1, rsel: 1'b1, rce: 1'b1,
        pc_mux_sel: 1'b1, push: 1'b0, pop: 1'b0, src_sel: 1'b0,
        stack_we: 1'b0, stack_re: 1'b0, out_ce: 1'b1,
        a_mux_sel: 2'b10, b_mux_sel: 2'b00};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOOP = 1'b1
    } state_t;

endpackage

// File: rtl/seq_dec_stack_tracker.sv
// Tracks stack occupancy, flags full/empty and a sticky over/underflow error, masks illegal push/pop.
// Latency: sp and flags update on the edge that issues the strobe; allow outputs are combinational on sp.
// Backpressure: none; illegal requests are dropped and recorded in stack_err.
module seq_dec_stack_tracker #(
    parameter int  STACK_DEPTH = 8,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clr,
    output logic            push_allow,
    output logic            pop_allow,
    output logic [SP_W-1:0] sp,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            stack_err
);

    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    assign stack_full  = (sp == SP_MAX);
    assign stack_empty = (sp == '0);
    assign push_allow  = !stack_full;
    assign pop_allow   = !stack_empty;

    // Occupancy counter with sticky error; requests beyond the limits only raise the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            stack_err <= 1'b0;
        end else if (clr) begin
            sp        <= '0;
            stack_err <= 1'b0;
        end else if (push) begin
            if (stack_full) stack_err <= 1'b1;
            else            sp        <= sp + SP_W'(1);
        end else if (pop) begin
            if (stack_empty) stack_err <= 1'b1;
            else             sp        <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/seq_instr_decoder.sv
// Registered microsequencer opcode decoder with REPEAT loop FSM; stack guard under SEQ_DEC_STACK_CHECK_EN.
// Latency: 1 cycle, the word for an opcode accepted at edge k is driven from edge k to edge k+1.
// Backpressure: instr_ready drops for the N cycles of a REPEAT loop, derived from registered state only.
module seq_instr_decoder #(
    parameter logic [2:0] DECODER_ID  = 3'b010,
    parameter int         STACK_DEPTH = 8,
    parameter int         LOOP_W      = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [2:0]                         id,
    input  logic [4:0]                         instr_in,
    input  logic                               cc_in,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [LOOP_W-1:0]                  d_in,
    output logic                               cen,
    output logic                               rst,
    output logic                               oen,
    output logic                               inc,
    output logic                               rsel,
    output logic                               rce,
    output logic                               pc_mux_sel,
    output logic                               push,
    output logic                               pop,
    output logic                               src_sel,
    output logic                               stack_we,
    output logic                               stack_re,
    output logic                               out_ce,
    output logic [1:0]                         a_mux_sel,
    output logic [1:0]                         b_mux_sel,
    output logic                               busy,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err
);

    import seq_dec_pkg::*;

    state_t            state, nxt_state;
    logic [LOOP_W-1:0] cnt, nxt_cnt;
    ctrl_word_t        word_q, nxt_word;
    logic              take;
    logic              push_allow;
    logic              pop_allow;

    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state == ST_LOOP);
    // Opcodes for another slice are consumed (handshake completes) but decoded as nothing.
    assign take        = instr_valid && instr_ready && (id == DECODER_ID);

`ifdef SEQ_DEC_STACK_CHECK_EN
    logic do_push, do_pop, do_clr;

    assign do_push = take && (instr_in == OP_PUSH_PC);
    assign do_pop  = take && (instr_in == OP_POP);
    assign do_clr  = take && (instr_in == OP_RESET);

    seq_dec_stack_tracker #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (do_push),
        .pop         (do_pop),
        .clr         (do_clr),
        .push_allow  (push_allow),
        .pop_allow   (pop_allow),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );
`else
    assign push_allow  = 1'b1;
    assign pop_allow   = 1'b1;
    assign sp          = '0;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

    // Next-state, loop count and next control word; the word is registered so outputs are glitch-free.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_word  = IDLE_WORD;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    case (instr_in)
                        OP_RESET: begin
                            nxt_word.rst = 1'b1;
                            nxt_cnt      = '0;
                        end
                        OP_FETCH_PC: nxt_word = FETCH_PC_WORD;
                        OP_FETCH_RD: begin
                            nxt_word           = FETCH_PC_WORD;
                            nxt_word.cen       = 1'b1;
                            nxt_word.a_mux_sel = 2'b00;
                            nxt_word.b_mux_sel = 2'b11;
                        end
                        OP_LOAD_R, OP_PUSH_PC: begin
                            nxt_word.rce       = 1'b1;
                            nxt_word.oen       = 1'b1;
                            nxt_word.inc       = 1'b1;
                            nxt_word.b_mux_sel = 2'b00;
                            if (instr_in == OP_PUSH_PC) begin
                                nxt_word.push     = push_allow;
                                nxt_word.stack_we = push_allow;
                            end
                        end
                        OP_POP: begin
                            nxt_word.oen      = 1'b1;
                            nxt_word.inc      = 1'b1;
                            nxt_word.pop      = pop_allow;
                            nxt_word.stack_re = pop_allow;
                        end
                        OP_LOAD_CNT: begin
                            nxt_word.oen = 1'b1;
                            nxt_word.inc = 1'b1;
                            nxt_cnt      = d_in;
                        end
                        OP_REPEAT: begin
                            if (cnt == '0) begin
                                nxt_word = DISABLE_WORD;
                            end else begin
                                nxt_state = ST_LOOP;
                                nxt_word  = FETCH_PC_WORD;
                            end
                        end
                        OP_COND_JUMP: begin
                            nxt_word.oen = 1'b1;
                            if (cc_in) begin
                                nxt_word.pc_mux_sel = 1'b0;
                                nxt_word.src_sel    = 1'b1;
                            end else begin
                                nxt_word.inc = 1'b1;
                            end
                        end
                        default: nxt_word = DISABLE_WORD;
                    endcase
                end
            end
            ST_LOOP: begin
                // cnt holds the LOOP cycles still to run including the current one.
                if (cnt <= LOOP_W'(1)) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt  = cnt - LOOP_W'(1);
                    nxt_word = FETCH_PC_WORD;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // State, loop count and output word registers; reset aborts any loop immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            word_q <= IDLE_WORD;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            word_q <= nxt_word;
        end
    end

    assign cen        = word_q.cen;
    assign rst        = word_q.rst;
    assign oen        = word_q.oen;
    assign inc        = word_q.inc;
    assign rsel       = word_q.rsel;
    assign rce        = word_q.rce;
    assign pc_mux_sel = word_q.pc_mux_sel;
    assign push       = word_q.push;
    assign pop        = word_q.pop;
    assign src_sel    = word_q.src_sel;
    assign stack_we   = word_q.stack_we;
    assign stack_re   = word_q.stack_re;
    assign out_ce     = word_q.out_ce;
    assign a_mux_sel  = word_q.a_mux_sel;
    assign b_mux_sel  = word_q.b_mux_sel;

endmodule

// File: tb/tb_seq_instr_decoder.sv
// Directed bench for seq_instr_decoder with an expected-result queue.
// Latency: each step drives one cycle and checks the registered result #1 after the edge.
// Backpressure: instr_valid is held during REPEAT to show it is ignored while instr_ready is low.
module tb_seq_instr_decoder;

`ifdef SEQ_DEC_STACK_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    typedef struct packed {
        logic cen, rst, oen, inc, rsel, rce, pcm, push, pop, src, swe, sre, oce;
        logic [1:0] a, b;
    } tw_t;

    typedef struct packed {
        tw_t        w;
        logic       busy, ready;
        logic [3:0] sp;
        logic       full, empty, err;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] id;
    logic [4:0] instr_in;
    logic       cc_in;
    logic       instr_valid;
    logic [7:0] d_in;
    logic       instr_ready;
    logic       cen, rst, oen, inc, rsel, rce, pc_mux_sel, push, pop, src_sel;
    logic       stack_we, stack_re, out_ce, busy, stack_full, stack_empty, stack_err;
    logic [1:0] a_mux_sel, b_mux_sel;
    logic [3:0] sp;

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];

    seq_instr_decoder dut (
        .clk(clk), .rst_n(rst_n), .id(id), .instr_in(instr_in), .cc_in(cc_in),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .d_in(d_in),
        .cen(cen), .rst(rst), .oen(oen), .inc(inc), .rsel(rsel), .rce(rce),
        .pc_mux_sel(pc_mux_sel), .push(push), .pop(pop), .src_sel(src_sel),
        .stack_we(stack_we), .stack_re(stack_re), .out_ce(out_ce),
        .a_mux_sel(a_mux_sel), .b_mux_sel(b_mux_sel), .busy(busy), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    function automatic tw_t w_idle();
        tw_t t = '0;
        t.pcm = 1'b1; t.a = 2'b10; t.b = 2'b10;
        return t;
    endfunction

    function automatic tw_t w_dis();
        tw_t t = w_idle();
        t.oen = 1'b1;
        return t;
    endfunction

    function automatic tw_t w_fpc();
        tw_t t = w_idle();
        t.oce = 1'b1; t.rsel = 1'b1; t.rce = 1'b1; t.oen = 1'b1; t.inc = 1'b1; t.b = 2'b00;
        return t;
    endfunction

    function automatic tw_t w_ldr();
        tw_t t = w_idle();
        t.rce = 1'b1; t.oen = 1'b1; t.inc = 1'b1; t.b = 2'b00;
        return t;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.w = '{cen, rst, oen, inc, rsel, rce, pc_mux_sel, push, pop, src_sel,
                stack_we, stack_re, out_ce, a_mux_sel, b_mux_sel};
        o.busy = busy; o.ready = instr_ready; o.sp = sp;
        o.full = stack_full; o.empty = stack_empty; o.err = stack_err;
        return o;
    endfunction

    task automatic expect_push(input tw_t ew, input logic eb, input logic er,
                               input logic [3:0] esp, input logic ef, input logic ee, input logic eer);
        obs_t e;
        e.w = ew; e.busy = eb; e.ready = er; e.sp = esp; e.full = ef; e.empty = ee; e.err = eer;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        obs_t o = sample();
        obs_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    // Drive one cycle (called just after a negedge), check the result after the next posedge.
    task automatic step(input logic v, input logic [4:0] op, input logic [2:0] idv, input logic cc,
                        input logic [7:0] d, input tw_t ew, input logic eb, input logic er,
                        input logic [3:0] esp, input logic ef, input logic ee, input logic eer,
                        input string tag);
        instr_valid = v; instr_in = op; id = idv; cc_in = cc; d_in = d;
        expect_push(ew, eb, er, esp, ef, ee, eer);
        @(posedge clk);
        #1;
        check(tag);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tw_t ew;
        rst_n = 1'b0; instr_valid = 1'b0; instr_in = 5'd0; id = 3'b010; cc_in = 1'b0; d_in = 8'd0;
        @(negedge clk); @(negedge clk);
        #1;
        expect_push(w_idle(), 0, 1, 0, 0, 1, 0);
        check("reset");
        rst_n = 1'b1;
        @(negedge clk);

        ew = w_fpc(); ew.cen = 1'b1; ew.a = 2'b00; ew.b = 2'b11;
        step(1, 5'b01001, 3'b010, 0, 0, ew,       0, 1, 0, 0, 1, 0, "fetch_rd");
        step(1, 5'b01001, 3'b011, 0, 0, w_idle(), 0, 1, 0, 0, 1, 0, "fetch_rd_other_id");
        step(0, 5'b01001, 3'b010, 0, 0, w_idle(), 0, 1, 0, 0, 1, 0, "no_valid");
        step(1, 5'b01000, 3'b010, 0, 0, w_fpc(),  0, 1, 0, 0, 1, 0, "fetch_pc");
        step(1, 5'b01010, 3'b010, 0, 0, w_ldr(),  0, 1, 0, 0, 1, 0, "load_r");
        step(1, 5'b10101, 3'b010, 0, 0, w_dis(),  0, 1, 0, 0, 1, 0, "undefined_op");

        ew = w_idle(); ew.oen = 1'b1; ew.inc = 1'b1;
        step(1, 5'b01101, 3'b010, 0, 8'd3, ew,    0, 1, 0, 0, 1, 0, "load_cnt3");
        step(1, 5'b01110, 3'b010, 0, 0, w_fpc(),  1, 0, 0, 0, 1, 0, "repeat3_c1");
        // Valid held with another slice's opcode and cc toggled: must be ignored in LOOP.
        step(1, 5'b01001, 3'b011, 1, 0, w_fpc(),  1, 0, 0, 0, 1, 0, "repeat3_c2");
        step(1, 5'b01111, 3'b010, 1, 0, w_fpc(),  1, 0, 0, 0, 1, 0, "repeat3_c3");
        step(1, 5'b01000, 3'b010, 0, 0, w_idle(), 0, 1, 0, 0, 1, 0, "repeat3_done");
        step(1, 5'b01110, 3'b010, 0, 0, w_dis(),  0, 1, 0, 0, 1, 0, "repeat0");

        ew = w_idle(); ew.oen = 1'b1; ew.pcm = 1'b0; ew.src = 1'b1;
        step(1, 5'b01111, 3'b010, 1, 0, ew,       0, 1, 0, 0, 1, 0, "cjump_taken");
        ew = w_idle(); ew.oen = 1'b1; ew.inc = 1'b1;
        step(1, 5'b01111, 3'b010, 0, 0, ew,       0, 1, 0, 0, 1, 0, "cjump_not_taken");

        ew = w_idle(); ew.oen = 1'b1; ew.inc = 1'b1; ew.pop = !EN; ew.sre = !EN;
        step(1, 5'b01100, 3'b010, 0, 0, ew,       0, 1, 0, 0, 1, EN, "pop_underflow");
        ew = w_idle(); ew.rst = 1'b1;
        step(1, 5'b00000, 3'b010, 0, 0, ew,       0, 1, 0, 0, 1, 0, "reset_op_clear");

        for (int i = 1; i <= 9; i++) begin
            ew = w_ldr();
            ew.push = !EN || (i <= 8);
            ew.swe  = !EN || (i <= 8);
            step(1, 5'b01011, 3'b010, 0, 0, ew, 0, 1,
                 EN ? 4'((i > 8) ? 8 : i) : 4'd0, EN && (i >= 8), !EN, EN && (i == 9),
                 $sformatf("push%0d", i));
        end
        ew = w_idle(); ew.oen = 1'b1; ew.inc = 1'b1; ew.pop = 1'b1; ew.sre = 1'b1;
        step(1, 5'b01100, 3'b010, 0, 0, ew, 0, 1, EN ? 4'd7 : 4'd0, 0, !EN, EN, "pop_err_sticky");
        ew = w_idle(); ew.rst = 1'b1;
        step(1, 5'b00000, 3'b010, 0, 0, ew, 0, 1, 0, 0, 1, 0, "reset_op_after_push");

        ew = w_idle(); ew.oen = 1'b1; ew.inc = 1'b1;
        step(1, 5'b01101, 3'b010, 0, 8'd5, ew,    0, 1, 0, 0, 1, 0, "load_cnt5");
        step(1, 5'b01110, 3'b010, 0, 0, w_fpc(),  1, 0, 0, 0, 1, 0, "repeat5_c1");
        step(0, 5'b00000, 3'b010, 0, 0, w_fpc(),  1, 0, 0, 0, 1, 0, "repeat5_c2");
        rst_n = 1'b0;
        #1;
        expect_push(w_idle(), 0, 1, 0, 0, 1, 0);
        check("reset_abort_loop");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 5'b00000, 3'b010, 0, 0, w_idle(), 0, 1, 0, 0, 1, 0, "after_release");
        step(1, 5'b01110, 3'b010, 0, 0, w_dis(),  0, 1, 0, 0, 1, 0, "repeat_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
